line_fill_ctrl: RTL and testbench

LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

---
 rtl/line_fill_ctrl_pkg.sv | 20 ++
 rtl/line_fill_ctrl_if.sv | 32 +++
 rtl/line_toggle_det.sv | 18 +
 rtl/line_fill_ctrl.sv | 90 +++++++++
 tb/tb_line_fill_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/line_fill_ctrl_pkg.sv
// Shared types and constants for the line-buffer fill controller.
package line_fill_ctrl_pkg;

  localparam int DEF_PIX_PER_LINE = 640;
  localparam int DEF_SRC_LINES    = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fill_state_e;

  // Source line that follows the given VGA source row, wrapping at the frame height.
  function automatic logic [6:0] next_src_line(input logic [6:0] cur, input int src_lines);
    int sum;
    sum = int'(cur) + 1;
    return 7'(sum % src_lines);
  endfunction

endpackage

// File: rtl/line_fill_ctrl_if.sv
// Bus between the line-fill controller, the VGA timing/source side and the line buffer.
interface line_fill_if;
  import line_fill_ctrl_pkg::*;

  logic [8:0]  VgaLineCount;
  // Source stream: a beat transfers on a rising edge where SRC_VALID and SRC_READY are
  // both high; SRC_DATA must be stable while SRC_VALID is high and SRC_READY is low.
  logic        SRC_VALID;
  logic [15:0] SRC_DATA;
  logic        SRC_READY;
  logic        SRC_LINE_REQ;
  logic [6:0]  SRC_LINE;
  logic [9:0]  LB_WR_ADDR;
  logic [15:0] LB_WR_DATA;
  logic        LB_WR_N;
  logic        FILL_BUSY;
  logic        OVR_CLR;
  logic        OVERRUN;
  fill_state_e FSM_STATE;

  modport master (
    output VgaLineCount, SRC_VALID, SRC_DATA, OVR_CLR,
    input  SRC_READY, SRC_LINE_REQ, SRC_LINE, LB_WR_ADDR, LB_WR_DATA, LB_WR_N,
           FILL_BUSY, OVERRUN, FSM_STATE
  );

  modport slave (
    input  VgaLineCount, SRC_VALID, SRC_DATA, OVR_CLR,
    output SRC_READY, SRC_LINE_REQ, SRC_LINE, LB_WR_ADDR, LB_WR_DATA, LB_WR_N,
           FILL_BUSY, OVERRUN, FSM_STATE
  );
endinterface

// File: rtl/line_toggle_det.sv
// Registers the line-buffer bank bit and flags any cycle where it changes.
module line_toggle_det (
  input  logic CLK,
  input  logic RST_N,
  input  logic bank_i,
  output logic toggle_o
);

  logic bank_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) bank_q <= 1'b0;
    else        bank_q <= bank_i;
  end

  assign toggle_o = bank_q ^ bank_i;

endmodule

// File: rtl/line_fill_ctrl.sv
// Fetches one source line per bank toggle and streams it into the idle line-buffer bank.
module line_fill_ctrl
  import line_fill_ctrl_pkg::*;
#(
  parameter int PIX_PER_LINE = DEF_PIX_PER_LINE,
  parameter int SRC_LINES    = DEF_SRC_LINES
) (
  input logic     CLK,
  input logic     RST_N,
  line_fill_if.slave bus
);

  localparam logic [9:0] LAST_BEAT = 10'(PIX_PER_LINE - 1);

  fill_state_e state_q, state_d;
  logic [9:0]  beat_q, beat_d;
  logic        ovr_q, ovr_d;
  logic        wr_v_q;
  logic [9:0]  wr_addr_q;
  logic [15:0] wr_data_q;
  logic        toggle;
  logic        accept;

  line_toggle_det u_toggle (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bank_i   (bus.VgaLineCount[1]),
    .toggle_o (toggle)
  );

  assign accept = bus.SRC_VALID && (state_q == ST_FILL);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ovr_d   = ovr_q;
    if (bus.OVR_CLR) ovr_d = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_REQ: begin
        state_d = ST_FILL;
        beat_d  = '0;
      end
      ST_FILL: begin
        if (accept) begin
          beat_d = beat_q + 10'd1;
          if (beat_q == LAST_BEAT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new bank always wins; an unfinished fill is abandoned and flagged.
    if (toggle) begin
      state_d = ST_REQ;
      if (state_q == ST_FILL) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      ovr_q     <= 1'b0;
      wr_v_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ovr_q   <= ovr_d;
      wr_v_q  <= accept;
      if (accept) begin
        wr_addr_q <= beat_q;
        wr_data_q <= bus.SRC_DATA;
      end
    end
  end

  assign bus.SRC_READY    = (state_q == ST_FILL);
  assign bus.SRC_LINE_REQ = (state_q == ST_REQ);
  assign bus.SRC_LINE     = (state_q == ST_REQ) ?
                            next_src_line(bus.VgaLineCount[8:2], SRC_LINES) : 7'd0;
  assign bus.LB_WR_ADDR   = wr_addr_q;
  assign bus.LB_WR_DATA   = wr_data_q;
  assign bus.LB_WR_N      = ~wr_v_q;
  assign bus.FILL_BUSY    = (state_q != ST_IDLE);
  assign bus.OVERRUN      = ovr_q;
  assign bus.FSM_STATE    = state_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Randomized bench for line_fill_ctrl against a line-level behavioural model.
module tb_line_fill_ctrl;
  import line_fill_ctrl_pkg::*;

  localparam int PIX = 640;
  localparam int SRC_LINES = 120;

  logic CLK;
  logic RST_N;
  line_fill_if bus ();

  line_fill_ctrl #(.PIX_PER_LINE(PIX), .SRC_LINES(SRC_LINES)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // reference model: a pending request, an active fill with its beat tally,
  // the sticky overrun flag, and the writes still owed to the line buffer
  bit m_bank, m_req, m_fill, m_ovr;
  int m_beats;
  logic [25:0] exp_q[$];
  logic [8:0] cur_vga;
  int n_wr;
  int last_req_line;
  int cyc;

  task automatic model_reset();
    m_bank = 0; m_req = 0; m_fill = 0; m_ovr = 0; m_beats = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input logic [8:0] vga);
    logic [25:0] e;
    chk("req", bus.SRC_LINE_REQ, m_req);
    chk("line", bus.SRC_LINE, m_req ? ((int'(vga >> 2) + 1) % SRC_LINES) : 0);
    chk("ready", bus.SRC_READY, m_fill);
    chk("busy", bus.FILL_BUSY, m_req || m_fill);
    chk("ovr", bus.OVERRUN, m_ovr);
    chk("wr_n", bus.LB_WR_N, exp_q.size() == 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!bus.LB_WR_N) begin
        chk("wr_addr", bus.LB_WR_ADDR, e[25:16]);
        chk("wr_data", bus.LB_WR_DATA, e[15:0]);
      end
    end
    if (!bus.LB_WR_N) n_wr++;
    if (bus.SRC_LINE_REQ) last_req_line = bus.SRC_LINE;
  endtask

  task automatic model_advance(input logic [8:0] vga, input logic valid,
                               input logic [15:0] data, input logic clr);
    bit tog, acc;
    tog = (vga[1] != m_bank);
    acc = m_fill && valid;
    if (acc) exp_q.push_back({10'(m_beats), data});
    if (clr) m_ovr = 0;
    if (tog && m_fill) m_ovr = 1;
    if (tog) begin
      m_req = 1; m_fill = 0;
    end else if (m_req) begin
      m_req = 0; m_fill = 1; m_beats = 0;
    end else if (acc) begin
      m_beats++;
      if (m_beats == PIX) m_fill = 0;
    end
    m_bank = vga[1];
  endtask

  // driver: one clock of stimulus, checked against the model before the edge
  task automatic step(input logic [8:0] vga, input logic valid,
                      input logic [15:0] data, input logic clr);
    @(negedge CLK);
    RST_N = 1'b1;
    bus.VgaLineCount = vga;
    bus.SRC_VALID = valid;
    bus.SRC_DATA = data;
    bus.OVR_CLR = clr;
    cur_vga = vga;
    #1;
    check_outputs(vga);
    model_advance(vga, valid, data, clr);
    cyc++;
  endtask

  task automatic do_reset(input logic [8:0] vga);
    @(negedge CLK);
    RST_N = 1'b0;
    bus.VgaLineCount = vga;
    cur_vga = vga;
    #1;
    chk("rst_ready", bus.SRC_READY, 0);
    chk("rst_req", bus.SRC_LINE_REQ, 0);
    chk("rst_line", bus.SRC_LINE, 0);
    chk("rst_addr", bus.LB_WR_ADDR, 0);
    chk("rst_data", bus.LB_WR_DATA, 0);
    chk("rst_wr_n", bus.LB_WR_N, 1);
    chk("rst_busy", bus.FILL_BUSY, 0);
    chk("rst_ovr", bus.OVERRUN, 0);
    chk("rst_state", bus.FSM_STATE, ST_IDLE);
    model_reset();
  endtask

  // mode 0: valid held high, data = beat index; 1: valid on alternate cycles; 2: random
  task automatic run_fill(input int mode);
    int budget;
    logic v;
    budget = 0;
    while ((m_req || m_fill) && budget < 4000) begin
      case (mode)
        0: v = 1'b1;
        1: v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      step(cur_vga, v, (mode == 0) ? 16'(m_beats) : 16'($urandom), 1'b0);
      budget++;
    end
    chk("fill_timeout", budget < 4000, 1);
    step(cur_vga, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic run_to_beat(input int n);
    int budget;
    budget = 0;
    while (!(m_fill && m_beats == n) && budget < 4000) begin
      step(cur_vga, 1'b1, 16'(m_beats), 1'b0);
      budget++;
    end
    chk("beat_timeout", budget < 4000, 1);
  endtask

  initial begin
    RST_N = 1'b0;
    bus.VgaLineCount = '0; bus.SRC_VALID = 0; bus.SRC_DATA = '0; bus.OVR_CLR = 0;
    cyc = 0; n_wr = 0; last_req_line = -1;
    model_reset();
    repeat (2) @(posedge CLK);
    do_reset(9'd0);
    repeat (4) step(9'd0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);

    // first request after reset, then a full fill with data equal to the beat index
    last_req_line = -1;
    step(9'd2, 1'b0, 16'h0, 1'b0);
    step(9'd2, 1'b0, 16'h0, 1'b0);
    chk("first_req_line", last_req_line, 1);
    n_wr = 0;
    run_fill(0);
    step(cur_vga, 1'b0, 16'h0, 1'b0);
    chk("full_fill_writes", n_wr, PIX);
    chk("full_fill_ovr", bus.OVERRUN, 0);
    chk("full_fill_idle", bus.FSM_STATE, ST_IDLE);

    // alternate-cycle valid
    n_wr = 0;
    step(9'd0, 1'b0, 16'h0, 1'b0);
    run_fill(1);
    step(cur_vga, 1'b0, 16'h0, 1'b0);
    chk("alt_fill_writes", n_wr, PIX);

    // overrun: bank switch at beat 300 together with a clear; the set must win
    step(9'd6, 1'b0, 16'h0, 1'b0);
    run_fill(0);
    step(9'd4, 1'b0, 16'h0, 1'b0);
    run_to_beat(300);
    last_req_line = -1;
    step(9'd6, 1'b1, 16'(m_beats), 1'b1);
    step(9'd6, 1'b0, 16'h0, 1'b0);
    chk("ovr_set", bus.OVERRUN, 1);
    chk("ovr_req_line", last_req_line, 2);
    run_fill(2);
    step(cur_vga, 1'b0, 16'h0, 1'b1);
    step(cur_vga, 1'b0, 16'h0, 1'b0);
    chk("ovr_cleared", bus.OVERRUN, 0);

    // source line wraps at the last source row
    step(9'd476, 1'b0, 16'h0, 1'b0);
    run_fill(2);
    last_req_line = -1;
    step(9'd478, 1'b0, 16'h0, 1'b0);
    step(9'd478, 1'b0, 16'h0, 1'b0);
    chk("wrap_line", last_req_line, 0);

    // reset in the middle of a fill; no writes until the next bank switch
    run_to_beat(100);
    do_reset(9'd476);
    n_wr = 0;
    repeat (40) step(9'd476, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
    chk("post_rst_writes", n_wr, 0);

    // random traffic with occasional bank switches and clears
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 399) == 0) cur_vga = 9'($urandom);
      step(cur_vga, 1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 63) == 0));
    end

    // bank bit already set at reset release counts as a switch
    do_reset(9'd10);
    last_req_line = -1;
    step(9'd10, 1'b0, 16'h0, 1'b0);
    step(9'd10, 1'b0, 16'h0, 1'b0);
    chk("rel_toggle_line", last_req_line, 3);
    run_fill(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
